// File: rtl/mult_shift_add_nbit_pkg.sv
// mult_shift_add_nbit_pkg
// Shared types and helpers for the sequential shift-and-add multiplier:
// the controller state encoding and a constant-evaluable clog2 used to size
// the iteration counter.
package mult_shift_add_nbit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, usable in parameter/localparam expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/mult_shift_add_nbit_adder.sv
// AdderNbit
// N-bit ripple-carry adder from the original combinational multiplier
// datapath; used by the sequential multiplier for the acc_hi + mcand step.
module AdderNbit
    import mult_shift_add_nbit_pkg::*;
#(
    parameter int N = 6
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] carry;

    // Ripple the carry bit by bit through a chain of full adders.
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < N; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[N];
    end

endmodule

// File: rtl/mult_shift_add_nbit.sv
// mult_shift_add_nbit
// Sequential shift-and-add multiplier: accepts N-bit a/b on a valid/ready
// handshake, performs one partial-product add per clock for N clocks, then
// holds the 2N-bit product on an output valid/ready handshake.
// Optional feature macro: MULT_SIGNED_EN (two's-complement operands/product,
// implemented as magnitude multiply followed by a conditional negate).
module mult_shift_add_nbit
    import mult_shift_add_nbit_pkg::*;
#(
    parameter int N = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           busy
);

    localparam int CW = clog2(N) + 1;

    state_t         state;
    state_t         next_state;
    logic [N-1:0]   mcand;
    logic [N-1:0]   acc_hi;
    logic [N-1:0]   acc_lo;
    logic [CW-1:0]  count;
    logic [N-1:0]   add_b;
    logic [N-1:0]   sum;
    logic           cout;
    logic [2*N-1:0] shifted;
    logic [2*N-1:0] result;
    logic [N-1:0]   mag_a;
    logic [N-1:0]   mag_b;
    logic           last_step;

    // Add mcand only when the current multiplier bit is set; adding zero
    // reproduces {0, acc_hi} so a single adder covers both cases.
    assign add_b = acc_lo[0] ? mcand : '0;

    AdderNbit #(.N(N)) u_adder (
        .a    (acc_hi),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // Accumulator after this step's add and right shift.
    assign shifted   = {cout, sum, acc_lo[N-1:1]};
    assign last_step = (count == CW'(N - 1));

`ifdef MULT_SIGNED_EN
    logic sign;

    // Multiply magnitudes; the most negative value maps to 2^(N-1), which
    // still fits an N-bit unsigned magnitude.
    assign mag_a  = a[N-1] ? -a : a;
    assign mag_b  = b[N-1] ? -b : b;
    assign result = sign ? -shifted : shifted;

    // Capture the product sign together with the operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            sign <= a[N-1] ^ b[N-1];
        end
    end
`else
    assign mag_a  = a;
    assign mag_b  = b;
    assign result = shifted;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs; in_ready and out_valid come from
    // distinct states so they can never be high together.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) next_state = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: load on accept, shift-add while running, latch the product
    // on the final step and keep it until the next result overwrites it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= mag_a;
                        acc_lo <= mag_b;
                        acc_hi <= '0;
                        count  <= '0;
                    end
                end
                RUN: begin
                    {acc_hi, acc_lo} <= shifted;
                    count            <= count + CW'(1);
                    if (last_step) begin
                        product <= result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_shift_add_nbit.sv
// tb_mult_shift_add_nbit
// Self-checking bench for mult_shift_add_nbit (N=6). Expected products come
// from plain integer multiplication; honours MULT_SIGNED_EN when defined.
`timescale 1ns/1ps
module tb_mult_shift_add_nbit;

   localparam int N       = 6;
   localparam int TIMEOUT = 100;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [N-1:0]   a;
   logic [N-1:0]   b;
   logic           out_valid;
   logic           out_ready;
   logic [2*N-1:0] product;
   logic           busy;

   int checkCount = 0;
   int passCount  = 0;

   mult_shift_add_nbit #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
   );

   // Free-running clock, 10 ns period.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
   endtask

   // Reference product from integer arithmetic on the operand values.
   function automatic logic [2*N-1:0] refProduct(input logic [N-1:0] x, input logic [N-1:0] y);
      longint px;
      longint py;
`ifdef MULT_SIGNED_EN
      px = x[N-1] ? longint'(x) - (longint'(1) << N) : longint'(x);
      py = y[N-1] ? longint'(y) - (longint'(1) << N) : longint'(y);
`else
      px = longint'(x);
      py = longint'(y);
`endif
      return (2*N)'(px * py);
   endfunction

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full transaction with optional back-pressure of 'hold' cycles.
   task automatic applyStimulus(input logic [N-1:0] x, input logic [N-1:0] y,
                                input logic [2*N-1:0] expected, input int hold,
                                input string tag);
      int cycles;
      logic [2*N-1:0] held;
      cycles = 0;
      while (!in_ready && cycles < TIMEOUT) begin
         step();
         cycles++;
      end
      checkOutput({tag, " in_ready"}, 64'(in_ready), 64'(1));
      a        = x;
      b        = y;
      in_valid = 1'b1;
      step();
      checkOutput({tag, " busy"}, 64'(busy), 64'(1));
      checkOutput({tag, " run in_ready"}, 64'(in_ready), 64'(0));
      cycles = 1;
      while (!out_valid && cycles < TIMEOUT) begin
         in_valid  = 1'($urandom);
         a         = N'($urandom);
         b         = N'($urandom);
         out_ready = 1'($urandom);
         step();
         cycles++;
      end
      out_ready = 1'b0;
      checkOutput({tag, " latency"}, 64'(cycles), 64'(N + 1));
      checkOutput({tag, " product"}, 64'(product), 64'(expected));
      checkOutput({tag, " exclusive"}, 64'(in_ready & out_valid), 64'(0));
      held = product;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom);
         a        = N'($urandom);
         b        = N'($urandom);
         step();
         checkOutput({tag, " hold valid"}, 64'(out_valid), 64'(1));
         checkOutput({tag, " hold in_ready"}, 64'(in_ready), 64'(0));
         checkOutput({tag, " hold product"}, 64'(product), 64'(held));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checkOutput({tag, " taken valid"}, 64'(out_valid), 64'(0));
      checkOutput({tag, " taken in_ready"}, 64'(in_ready), 64'(1));
      checkOutput({tag, " retained"}, 64'(product), 64'(expected));
   endtask

   // Reset pulse in the third RUN cycle must discard the operation.
   task automatic resetMidRun();
      a        = N'($urandom);
      b        = N'($urandom);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      rst = 1'b1;
      #1;
      checkOutput("rst_run in_ready", 64'(in_ready), 64'(1));
      checkOutput("rst_run out_valid", 64'(out_valid), 64'(0));
      checkOutput("rst_run busy", 64'(busy), 64'(0));
      checkOutput("rst_run product", 64'(product), 64'(0));
      step();
      rst = 1'b0;
      step();
      applyStimulus(N'(5), N'(7), (2*N)'(35), 0, "after_rst");
   endtask

   // Three operand pairs with in_valid and out_ready held high.
   task automatic backToBack();
      logic [N-1:0]   xs[3];
      logic [N-1:0]   ys[3];
      logic [2*N-1:0] expq[$];
      logic [2*N-1:0] exp;
      int sent;
      int got;
      int lastCycle;
      sent      = 0;
      got       = 0;
      lastCycle = -1;
      for (int i = 0; i < 3; i++) begin
         xs[i] = N'($urandom);
         ys[i] = N'($urandom);
      end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int cyc = 0; cyc < 6 * (N + 2) && got < 3; cyc++) begin
         checkOutput("b2b exclusive", 64'(in_ready & out_valid), 64'(0));
         if (out_valid) begin
            exp = (expq.size() > 0) ? expq.pop_front() : 'x;
            checkOutput("b2b product", 64'(product), 64'(exp));
            if (lastCycle >= 0) checkOutput("b2b spacing", 64'(cyc - lastCycle), 64'(N + 2));
            lastCycle = cyc;
            got++;
         end
         if (in_ready) begin
            if (sent < 3) begin
               a = xs[sent];
               b = ys[sent];
               expq.push_back(refProduct(xs[sent], ys[sent]));
               sent++;
               in_valid = 1'b1;
            end else begin
               in_valid = 1'b0;
            end
         end
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      checkOutput("b2b count", 64'(got), 64'(3));
   endtask

   // Test sequence: reset, directed cases, back-pressure, reset mid-run,
   // back-to-back, exhaustive sweep and randomized back-pressure.
   initial begin
      logic [N-1:0] rx;
      logic [N-1:0] ry;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      step();
      step();
      checkOutput("reset in_ready", 64'(in_ready), 64'(1));
      checkOutput("reset out_valid", 64'(out_valid), 64'(0));
      checkOutput("reset busy", 64'(busy), 64'(0));
      checkOutput("reset product", 64'(product), 64'(0));
      rst = 1'b0;
      step();

`ifdef MULT_SIGNED_EN
      applyStimulus(6'h20, 6'h20, 12'h400, 0, "neg_min_sq");
      applyStimulus(6'h3F, 6'h01, 12'hFFF, 0, "neg_one");
      applyStimulus(6'h20, 6'h1F, 12'hC20, 0, "neg_min_pos_max");
      applyStimulus(6'h00, 6'h3B, 12'h000, 0, "zero_neg");
`else
      applyStimulus(6'd63, 6'd63, 12'hF81, 0, "max");
      applyStimulus(6'd0, 6'd45, 12'd0, 0, "zero");
      applyStimulus(6'd45, 6'd1, 12'd45, 0, "one");
`endif

      rx = N'($urandom);
      ry = N'($urandom);
      applyStimulus(rx, ry, refProduct(rx, ry), 20, "backpressure");

      resetMidRun();
      backToBack();

      for (int x = 0; x < (1 << N); x++) begin
         for (int y = 0; y < (1 << N); y++) begin
            applyStimulus(N'(x), N'(y), refProduct(N'(x), N'(y)), 0, "sweep");
         end
      end

      for (int i = 0; i < 40; i++) begin
         rx = N'($urandom);
         ry = N'($urandom);
         applyStimulus(rx, ry, refProduct(rx, ry), int'($urandom_range(0, 5)), "random");
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/mult_shift_add_nbit.md
# mult_shift_add_nbit

Parametrised sequential shift-and-add multiplier built on the team's N-bit ripple adder. Accepts two N-bit operands over a valid/ready handshake, iterates one partial-product add per clock, and presents a 2N-bit product over a second valid/ready handshake. It is the sequential, handshaked successor to the combinational N-bit adder datapath in the N-bit multiplier project.

## Interface
- N, default 6: operand width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a/b are valid this cycle.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  N  multiplicand.
- b  input  N  multiplier.
- out_valid  output  1  product is valid; held until accepted.
- out_ready  input  1  consumer accepts product this cycle.
- product  output  2N  result; stable while out_valid is high.
- busy  output  1  high in RUN or DONE.
- Reset values: in_ready=1, out_valid=0, busy=0, product=0.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE and clears all registers.
- IDLE: in_ready=1. On in_valid&&in_ready: load mcand<=a, acc_lo<=b, acc_hi<=0, count<=0, go to RUN.
- RUN (exactly N cycles): if acc_lo[0], {cout,sum}=acc_hi+mcand via adder (cin=0), else {cout,sum}={0,acc_hi}; then {acc_hi,acc_lo}<={cout,sum,acc_lo[N-1:1]}; count<=count+1. On count==N-1: latch product<={acc_hi,acc_lo} after final shift, go to DONE.
- DONE: out_valid=1, product held. On out_ready: go to IDLE, out_valid<=0. product retains its value after acceptance until the next DONE.
- Inputs a/b are ignored outside the accepting cycle; in_valid outside IDLE has no effect.
- out_ready outside DONE has no effect.
- count width = clog2(N)+1; accumulator 2N+1 bits including cout; no overflow possible (unsigned product ≤ (2^N−1)^2).
- rst asserted mid-RUN or mid-DONE: immediate return to IDLE, result discarded, outputs at reset values.

## Timing
- Accept at edge E0 → RUN for edges E1..EN → out_valid high after edge EN (latency N+1 cycles accept-to-valid).
- Back-to-back: with out_ready held high, out_valid is high for one cycle, in_ready rises the following cycle; throughput one product per N+2 cycles.
- in_ready and out_valid are never high simultaneously.
- out_ready held low: DONE persists indefinitely, product stable.

## Configuration
- MULT_SIGNED_EN defined: a, b and product are two's complement. At accept, mcand<=|a|, multiplier<=|b| (N-bit unsigned magnitude; −2^(N−1) maps to 2^(N−1)), sign<=a[N−1]^b[N−1]. Entering DONE, product<=sign ? −acc : acc (2N-bit two's-complement negate). Latency unchanged.
- Not defined: operands and product unsigned; no sign register, no negation logic.

## Structure
- Shared package: state enum (IDLE, RUN, DONE) and a count-width constant function clog2.
- One sub-module: the existing N-bit ripple adder (AdderNbit, parameter N, ports a, b, cin, sum, cout), instantiated once for the acc_hi+mcand step; the negation under MULT_SIGNED_EN is inline.

## Test plan
- N=6, unsigned: a=63, b=63, out_ready=1 → out_valid exactly 7 cycles after accept, product=12'hF81 (3969).
- N=6: a=0, b=45 and a=45, b=1 → product=0 and product=45; exhaustive 4096-pair sweep matches a*b.
- Back-pressure: out_ready=0 for 20 cycles after DONE → out_valid, product stable, in_ready=0, in_valid pulses ignored; out_ready=1 → IDLE next cycle.
- Reset mid-RUN: rst pulse at cycle 3 of RUN → in_ready=1, out_valid=0, product=0; next operation a=5, b=7 → 35.
- MULT_SIGNED_EN, N=6: (−32)×(−32) → 12'h400; (−1)×1 → 12'hFFF; (−32)×31 → 12'hC20 (−992); 0×(−5) → 0.
- Back-to-back with in_valid and out_ready held high: three operand pairs → products emitted every 8 cycles, in order.
